uart_tx_dev: RTL and testbench

- Memory-mapped UART transmitter for the simple system. Sits downstream of the system bus as one extra device slot, alongside RAM, SimCtrl and Timer.
- Software writes bytes into a TX FIFO. The block serialises them as 8N1 frames on uart_tx_o at a programmable bit period.
- Raises a level interrupt when transmission has drained, giving real-console output on FPGA builds where simulator_ctrl is unavailable.

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 47 ++++
 rtl/uart_tx_dev.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_dev.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared register offsets and transmit FSM state encoding for the memory-mapped UART transmitter.
package uart_tx_pkg;

    localparam logic [9:0] UART_TXDATA = 10'h0;
    localparam logic [9:0] UART_STATUS = 10'h4;
    localparam logic [9:0] UART_DIV    = 10'h8;
    localparam logic [9:0] UART_IRQ_EN = 10'hC;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO; pointers carry an extra wrap bit to tell full from empty.
module uart_tx_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  logic                   pop,
    input  logic [Width-1:0]       wdata,
    output logic [Width-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] level
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign level   = wptr - rptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, programmable bit period and drain interrupt.
//   state   | meaning
//   TxIdle  | line high, waiting for a FIFO byte
//   TxStart | start bit (low) for DIV+1 cycles
//   TxData  | eight data bits, LSB first
//   TxStop  | stop bit (high); chains straight into the next frame if data is queued
module uart_tx_dev
    import uart_tx_pkg::*;
#(
    parameter int          DataWidth    = 32,
    parameter int          AddressWidth = 32,
    parameter int          FifoDepth    = 16,
    parameter logic [15:0] ResetDiv     = 16'd433
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    uart_req_i,
    input  logic                    uart_we_i,
    input  logic [3:0]              uart_be_i,
    input  logic [AddressWidth-1:0] uart_addr_i,
    input  logic [DataWidth-1:0]    uart_wdata_i,
    output logic                    uart_rvalid_o,
    output logic [DataWidth-1:0]    uart_rdata_o,
    output logic                    uart_err_o,
    output logic                    uart_tx_o,
    output logic                    uart_irq_o
);

    localparam int LW = $clog2(FifoDepth) + 1;

    logic [9:0]           offset;
    logic [15:0]          div_q;
    logic                 irq_en_q;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [7:0]           fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LW-1:0]        fifo_level;
    logic                 rsp_err;
    logic [DataWidth-1:0] rsp_data;
    logic                 busy;
    logic                 bit_done;
    logic                 unused_bits;

    uart_tx_state_e state_q;
    logic [15:0]    cnt_q;
    logic [15:0]    reload_q;
    logic [7:0]     shift_q;
    logic [2:0]     idx_q;

    assign offset      = {uart_addr_i[9:2], 2'b00};
    assign busy        = (state_q != TxIdle);
    assign bit_done    = (cnt_q == 16'd0);
    assign unused_bits = ^{uart_addr_i[AddressWidth-1:10], uart_addr_i[1:0],
                           uart_be_i[3:2], uart_wdata_i[DataWidth-1:16]};

    // A frame may begin from idle or directly at the end of a stop bit.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == TxIdle) || ((state_q == TxStop) && bit_done));

    uart_tx_fifo #(
        .Width(8),
        .Depth(FifoDepth)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (uart_wdata_i[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        rsp_err   = 1'b0;
        rsp_data  = '0;
        fifo_push = 1'b0;
        if (uart_req_i) begin
            case (offset)
                UART_TXDATA: begin
                    if (uart_we_i && uart_be_i[0]) begin
                        if (fifo_full) rsp_err = 1'b1;
                        else           fifo_push = 1'b1;
                    end
                end
                UART_STATUS: begin
                    if (uart_we_i) rsp_err = 1'b1;
                    else rsp_data = DataWidth'({16'h0, 8'(fifo_level), 5'h0,
                                                busy, fifo_empty, fifo_full});
                end
                UART_DIV: begin
                    if (!uart_we_i) rsp_data = DataWidth'({16'h0, div_q});
                end
                UART_IRQ_EN: begin
                    if (!uart_we_i) rsp_data = DataWidth'({31'h0, irq_en_q});
                end
                default: rsp_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            uart_rvalid_o <= 1'b0;
            uart_rdata_o  <= '0;
            uart_err_o    <= 1'b0;
        end else begin
            uart_rvalid_o <= uart_req_i;
            uart_rdata_o  <= rsp_data;
            uart_err_o    <= rsp_err;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q    <= ResetDiv;
            irq_en_q <= 1'b0;
        end else if (uart_req_i && uart_we_i) begin
            if (offset == UART_DIV) begin
                if (uart_be_i[0]) div_q[7:0]  <= uart_wdata_i[7:0];
                if (uart_be_i[1]) div_q[15:8] <= uart_wdata_i[15:8];
            end
            if (offset == UART_IRQ_EN && uart_be_i[0]) irq_en_q <= uart_wdata_i[0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= TxIdle;
            cnt_q     <= 16'd0;
            reload_q  <= 16'd0;
            shift_q   <= 8'd0;
            idx_q     <= 3'd0;
            uart_tx_o <= 1'b1;
        end else begin
            case (state_q)
                TxIdle: begin
                    uart_tx_o <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q   <= fifo_rdata;
                        cnt_q     <= div_q;
                        reload_q  <= div_q;
                        idx_q     <= 3'd0;
                        uart_tx_o <= 1'b0;
                        state_q   <= TxStart;
                    end
                end
                TxStart: begin
                    if (bit_done) begin
                        cnt_q     <= reload_q;
                        idx_q     <= 3'd0;
                        uart_tx_o <= shift_q[0];
                        state_q   <= TxData;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                TxData: begin
                    if (bit_done) begin
                        cnt_q <= reload_q;
                        if (idx_q == 3'd7) begin
                            uart_tx_o <= 1'b1;
                            state_q   <= TxStop;
                        end else begin
                            shift_q   <= {1'b0, shift_q[7:1]};
                            idx_q     <= idx_q + 3'd1;
                            uart_tx_o <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                TxStop: begin
                    if (bit_done) begin
                        if (!fifo_empty) begin
                            shift_q   <= fifo_rdata;
                            cnt_q     <= div_q;
                            reload_q  <= div_q;
                            idx_q     <= 3'd0;
                            uart_tx_o <= 1'b0;
                            state_q   <= TxStart;
                        end else begin
                            state_q <= TxIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: begin
                    uart_tx_o <= 1'b1;
                    state_q   <= TxIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) uart_irq_o <= 1'b0;
        else       uart_irq_o <= irq_en_q && fifo_empty && (state_q == TxIdle);
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Randomized self-checking bench for uart_tx_dev: bus register model plus a frame-level line monitor.
module tb_uart_tx_dev;

    localparam int         Depth    = 16;
    localparam logic [9:0] A_TXDATA = 10'h0;
    localparam logic [9:0] A_STATUS = 10'h4;
    localparam logic [9:0] A_DIV    = 10'h8;
    localparam logic [9:0] A_IRQEN  = 10'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] m_div = 16'd433;
    logic        m_irq_en = 1'b0;
    logic [7:0]  exp_q[$];
    int          start_q[$];
    logic        mon_en = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_dev #(.FifoDepth(Depth)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .uart_req_i   (req),
        .uart_we_i    (we),
        .uart_be_i    (be),
        .uart_addr_i  (addr),
        .uart_wdata_i (wdata),
        .uart_rvalid_o(rvalid),
        .uart_rdata_o (rdata),
        .uart_err_o   (err),
        .uart_tx_o    (tx),
        .uart_irq_o   (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Call right after a falling edge; returns one falling edge later with the response.
    task automatic bus_xfer(input logic w, input logic [3:0] b, input logic [9:0] off,
                            input logic [31:0] d, output logic [31:0] rd, output logic e);
        req = 1'b1; we = w; be = b; addr = 32'h0003_0000 | {22'h0, off}; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0; be = 4'h0; wdata = 32'h0;
        rd = rdata;
        e  = err;
        check_eq("rvalid", {31'h0, rvalid}, 32'h1);
        if (w) check_eq("wr_rdata_zero", rdata, 32'h0);
    endtask

    task automatic reg_write(input logic [9:0] off, input logic [3:0] b, input logic [31:0] d,
                             input logic exp_err);
        logic [31:0] rd;
        logic        e;
        bus_xfer(1'b1, b, off, d, rd, e);
        check_eq("wr_err", {31'h0, e}, {31'h0, exp_err});
        if (!exp_err) begin
            if (off == A_DIV) begin
                if (b[0]) m_div[7:0]  = d[7:0];
                if (b[1]) m_div[15:8] = d[15:8];
            end else if (off == A_IRQEN && b[0]) begin
                m_irq_en = d[0];
            end
        end
    endtask

    task automatic reg_read(input string tag, input logic [9:0] off, input logic [31:0] exp,
                            input logic exp_err);
        logic [31:0] rd;
        logic        e;
        bus_xfer(1'b0, 4'hF, off, 32'h0, rd, e);
        check_eq(tag, rd, exp);
        check_eq("rd_err", {31'h0, e}, {31'h0, exp_err});
    endtask

    task automatic push_b(input logic [7:0] b, input logic [3:0] bev, input logic exp_err);
        logic [31:0] rd;
        logic [31:0] d;
        logic        e;
        d = $urandom;
        d[7:0] = b;
        bus_xfer(1'b1, bev, A_TXDATA, d, rd, e);
        check_eq("push_err", {31'h0, e}, {31'h0, exp_err});
        if (bev[0] && !exp_err) exp_q.push_back(b);
    endtask

    task automatic wait_idle();
        logic [31:0] rd;
        logic        e;
        logic        done;
        done = 1'b0;
        for (int k = 0; k < 3000 && !done; k++) begin
            bus_xfer(1'b0, 4'hF, A_STATUS, 32'h0, rd, e);
            if (rd[2:0] == 3'b010) done = 1'b1;
        end
        check_eq("drain", {31'h0, done}, 32'h1);
        check_eq("exp_q_left", exp_q.size(), 32'h0);
    endtask

    // Line monitor: each frame is ten bit periods of DIV+1 cycles: 0, data LSB first, 1.
    int         mon_d;
    int         mon_n;
    int         mon_bad;
    int         mon_b;
    logic       mon_bit;
    logic [7:0] mon_exp;
    logic [7:0] mon_got;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                mon_d   = int'(m_div);
                mon_n   = 10 * (mon_d + 1);
                mon_bad = 0;
                mon_got = 8'h0;
                start_q.push_back(cyc);
                check_eq("frame_expected", {31'h0, exp_q.size() > 0}, 32'h1);
                mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h0;
                for (int i = 0; i < mon_n; i++) begin
                    if (i > 0) @(negedge clk);
                    mon_b = i / (mon_d + 1);
                    if (mon_b == 0)      mon_bit = 1'b0;
                    else if (mon_b == 9) mon_bit = 1'b1;
                    else                 mon_bit = mon_exp[mon_b-1];
                    if (tx !== mon_bit) mon_bad++;
                    if (mon_b >= 1 && mon_b <= 8 && (i % (mon_d + 1)) == mon_d / 2)
                        mon_got[mon_b-1] = tx;
                end
                check_eq("frame_byte", {24'h0, mon_got}, {24'h0, mon_exp});
                check_eq("frame_shape", mon_bad, 32'h0);
            end
        end
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] d;
        logic        e;
        logic        full_pre;
        logic        pop_now;
        logic [3:0]  bev;
        int          occ;
        int          accepted;
        int          bad;
        int          nb;

        repeat (3) @(negedge clk);
        check_eq("rst_tx", {31'h0, tx}, 32'h1);
        check_eq("rst_irq", {31'h0, irq}, 32'h0);
        check_eq("rst_rvalid", {31'h0, rvalid}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_rdata", rdata, 32'h0);
        reg_read("rst_status", A_STATUS, 32'h2, 1'b0);
        reg_read("rst_div", A_DIV, 32'd433, 1'b0);
        reg_read("rst_irqen", A_IRQEN, 32'h0, 1'b0);

        // Error responses and be[0]=0 no-op push.
        reg_read("bad_off_rd", 10'h010, 32'h0, 1'b1);
        reg_write(A_STATUS, 4'hF, 32'hFFFF_FFFF, 1'b1);
        reg_write(10'h01C, 4'hF, 32'h0000_1234, 1'b1);
        reg_read("div_after_bad", A_DIV, {16'h0, m_div}, 1'b0);
        push_b(8'h3C, 4'b1110, 1'b0);
        reg_read("txdata_rd", A_TXDATA, 32'h0, 1'b0);
        reg_read("no_push_status", A_STATUS, 32'h2, 1'b0);

        // 0xA5 at DIV=3: line low one cycle after the push; busy through the frame.
        reg_write(A_DIV, 4'b0011, 32'h3, 1'b0);
        push_b(8'hA5, 4'h1, 1'b0);
        check_eq("push_tx_high", {31'h0, tx}, 32'h1);
        @(negedge clk);
        check_eq("start_latency", {31'h0, tx}, 32'h0);
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            bus_xfer(1'b0, 4'hF, A_STATUS, 32'h0, rd, e);
            if (rd[2:0] != 3'b110) bad++;
        end
        check_eq("busy_in_frame", bad, 32'h0);
        wait_idle();

        // Randomized rounds: DIV readback under random byte enables, then bytes at a small DIV.
        for (int r = 0; r < 5; r++) begin
            reg_write(A_DIV, $urandom_range(0, 15), $urandom, 1'b0);
            reg_read("div_rd", A_DIV, {16'h0, m_div}, 1'b0);
            d = $urandom;
            d[15:0] = 16'($urandom_range(0, 3));
            reg_write(A_DIV, 4'hF, d, 1'b0);
            reg_read("div_small", A_DIV, {16'h0, m_div}, 1'b0);
            nb = $urandom_range(1, 6);
            for (int k = 0; k < nb; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                bev = 4'($urandom);
                bev[0] = ($urandom_range(0, 3) != 0);
                push_b(8'($urandom), bev, 1'b0);
            end
            wait_idle();
        end

        // DIV=0 back-to-back pushes: overflow while the FSM pops on a 10-cycle cadence.
        reg_write(A_DIV, 4'b0011, 32'h0, 1'b0);
        start_q.delete();
        occ = 0;
        accepted = 0;
        for (int n = 1; n <= 40; n++) begin
            full_pre = (occ == Depth);
            pop_now  = (n >= 2) && ((n - 2) % 10 == 0) && (occ > 0);
            push_b(8'($urandom), 4'h1, full_pre);
            if (!full_pre) begin
                occ++;
                accepted++;
            end
            if (pop_now) occ--;
        end
        reg_read("full_status", A_STATUS,
                 {16'h0, 8'(occ), 5'h0, 1'b1, occ == 0, occ == Depth}, 1'b0);
        wait_idle();
        check_eq("frame_count", start_q.size(), accepted);
        bad = 0;
        for (int k = 1; k < start_q.size(); k++)
            if (start_q[k] - start_q[k-1] != 10) bad++;
        check_eq("no_gap", bad, 32'h0);

        // DIV changed mid-frame only affects the next frame.
        reg_write(A_DIV, 4'b0011, 32'h2, 1'b0);
        start_q.delete();
        push_b(8'h96, 4'h1, 1'b0);
        push_b(8'h0F, 4'h1, 1'b0);
        repeat (5) @(negedge clk);
        reg_write(A_DIV, 4'b0011, 32'h1, 1'b0);
        wait_idle();
        check_eq("midframe_len", start_q[1] - start_q[0], 32'd30);

        // Interrupt: high when drained, low one cycle after a push until one cycle after STOP.
        reg_write(A_IRQEN, 4'hF, 32'h1, 1'b0);
        @(negedge clk);
        check_eq("irq_idle", {31'h0, irq}, 32'h1);
        push_b(8'h5A, 4'h1, 1'b0);
        check_eq("irq_at_push", {31'h0, irq}, 32'h1);
        bad = 0;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            if (irq !== 1'b0) bad++;
        end
        check_eq("irq_in_frame", bad, 32'h0);
        @(negedge clk);
        check_eq("irq_after_stop", {31'h0, irq}, 32'h1);
        reg_write(A_IRQEN, 4'hF, 32'h0, 1'b0);
        @(negedge clk);
        check_eq("irq_disabled", {31'h0, irq}, 32'h0);
        wait_idle();

        // Reset during data bit 3 of 0x55 at DIV=3.
        mon_en = 1'b0;
        reg_write(A_DIV, 4'b0011, 32'h3, 1'b0);
        push_b(8'h55, 4'h1, 1'b0);
        push_b(8'hFF, 4'h1, 1'b0);
        exp_q.delete();
        repeat (17) @(negedge clk);
        check_eq("pre_rst_tx", {31'h0, tx}, 32'h0);
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0003_0004;
        @(posedge clk);
        #1;
        check_eq("pre_rst_rvalid", {31'h0, rvalid}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check_eq("async_rst_tx", {31'h0, tx}, 32'h1);
        check_eq("async_rst_rvalid", {31'h0, rvalid}, 32'h0);
        @(negedge clk);
        req = 1'b0;
        rst = 1'b0;
        m_div = 16'd433;
        m_irq_en = 1'b0;
        @(negedge clk);
        reg_read("post_rst_status", A_STATUS, 32'h2, 1'b0);
        reg_read("post_rst_div", A_DIV, 32'd433, 1'b0);
        check_eq("post_rst_irq", {31'h0, irq}, 32'h0);
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        check_eq("post_rst_line_idle", bad, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
